// File: rtl/keygen_search_ctrl.sv
// keygen_search_ctrl
// Drives the GCD key-validity unit during RSA key-pair search. Takes candidate
// prime pairs over a valid/ready handshake, kicks one GCD evaluation per pair,
// flushes the GCD between attempts, and stops on the first valid pair (done) or
// when the attempt budget runs out (fail). Every output is a flop.
`timescale 1ns/1ps

module keygen_search_ctrl #(
  parameter int HALF_KEY_LENGTH = 16,
  parameter int e_WIDTH         = 3,
  parameter int MAX_TRIES       = 16,
  parameter int TIMEOUT         = 128,
  parameter int ATT_W           = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic                           cand_valid,
  output logic                           cand_ready,
  input  logic [HALF_KEY_LENGTH-1:0]     cand_p1,
  input  logic [HALF_KEY_LENGTH-1:0]     cand_p2,
  output logic                           gcd_rst,
  output logic                           gcd_start,
  output logic [HALF_KEY_LENGTH-1:0]     gcd_p1,
  output logic [HALF_KEY_LENGTH-1:0]     gcd_p2,
  input  logic                           gcd_ready,
  input  logic                           gcd_valid,
  input  logic [2*HALF_KEY_LENGTH-1:0]   gcd_mod,
  input  logic [2*HALF_KEY_LENGTH-1:0]   gcd_fn,
  output logic                           busy,
  output logic                           done,
  output logic                           fail,
  output logic [2*HALF_KEY_LENGTH-1:0]   key_mod,
  output logic [2*HALF_KEY_LENGTH-1:0]   key_fn,
  output logic [ATT_W-1:0]               attempts
);

  localparam int H     = HALF_KEY_LENGTH;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [ATT_W-1:0] MAX_ATT  = ATT_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Elaboration-time guard against a parameter set the controller cannot honour.
  if (MAX_TRIES < 1 || MAX_TRIES >= (1 << ATT_W) || TIMEOUT < 2 || e_WIDTH < 1) begin : g_param_check
    $error("keygen_search_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_REQ   = 3'd2,
    S_KICK  = 3'd3,
    S_WAIT  = 3'd4,
    S_EVAL  = 3'd5,
    S_DONE  = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic             pair_bad_s;

  // A pair with equal or zero halves can never yield a key, so it is discarded
  // without spending a GCD run (it still consumes an attempt).
  assign pair_bad_s = (cand_p1 == cand_p2) ||
                      (cand_p1 == {H{1'b0}}) ||
                      (cand_p2 == {H{1'b0}});

  // Search sequencer: state, attempt/timer bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      timer_r    <= '0;
      cand_ready <= 1'b0;
      gcd_rst    <= 1'b0;
      gcd_start  <= 1'b0;
      gcd_p1     <= '0;
      gcd_p2     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      key_mod    <= '0;
      key_fn     <= '0;
      attempts   <= '0;
    end else begin
      // Pulse-like outputs fall back to their idle values unless a transition
      // below re-asserts them for the state being entered.
      gcd_start  <= 1'b0;
      cand_ready <= 1'b0;
      gcd_rst    <= 1'b1;
      case (state_r)
        S_IDLE, S_DONE, S_FAIL: begin
          if (go) begin
            done     <= 1'b0;
            fail     <= 1'b0;
            attempts <= '0;
            busy     <= 1'b1;
            gcd_rst  <= 1'b0;
            state_r  <= S_FLUSH;
          end else begin
            state_r  <= state_r;
          end
        end
        S_FLUSH: begin
          if (attempts >= MAX_ATT) begin
            fail       <= 1'b1;
            busy       <= 1'b0;
            state_r    <= S_FAIL;
          end else begin
            cand_ready <= 1'b1;
            state_r    <= S_REQ;
          end
        end
        S_REQ: begin
          if (cand_valid && cand_ready) begin
            attempts <= attempts + ATT_W'(1);
            gcd_p1   <= cand_p1;
            gcd_p2   <= cand_p2;
            if (pair_bad_s) begin
              gcd_rst   <= 1'b0;
              state_r   <= S_FLUSH;
            end else begin
              gcd_start <= 1'b1;
              state_r   <= S_KICK;
            end
          end else begin
            cand_ready <= 1'b1;
          end
        end
        S_KICK: begin
          timer_r <= '0;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (gcd_ready) begin
            state_r <= S_EVAL;
          end else if (timer_r == TMR_LAST) begin
            gcd_rst <= 1'b0;
            state_r <= S_FLUSH;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        S_EVAL: begin
          if (gcd_valid) begin
            key_mod <= gcd_mod;
            key_fn  <= gcd_fn;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_DONE;
          end else begin
            gcd_rst <= 1'b0;
            state_r <= S_FLUSH;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keygen_search_ctrl.sv
// Self-checking bench for keygen_search_ctrl with a behavioural GCD unit.
`timescale 1ns/1ps

module tb_keygen_search_ctrl;

  localparam int H  = 16;
  localparam int EW = 3;
  localparam int MT = 2;
  localparam int TO = 128;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            go;
  logic            cand_valid;
  logic            cand_ready;
  logic [H-1:0]    cand_p1;
  logic [H-1:0]    cand_p2;
  logic            gcd_rst;
  logic            gcd_start;
  logic [H-1:0]    gcd_p1;
  logic [H-1:0]    gcd_p2;
  logic            gcd_ready = 1'b0;
  logic            gcd_valid = 1'b0;
  logic [2*H-1:0]  gcd_mod = '0;
  logic [2*H-1:0]  gcd_fn = '0;
  logic            busy;
  logic            done;
  logic            fail;
  logic [2*H-1:0]  key_mod;
  logic [2*H-1:0]  key_fn;
  logic [AW-1:0]   attempts;

  int checks = 0;
  int failures = 0;

  keygen_search_ctrl #(
    .HALF_KEY_LENGTH(H), .e_WIDTH(EW), .MAX_TRIES(MT), .TIMEOUT(TO), .ATT_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_p1(cand_p1), .cand_p2(cand_p2),
    .gcd_rst(gcd_rst), .gcd_start(gcd_start),
    .gcd_p1(gcd_p1), .gcd_p2(gcd_p2),
    .gcd_ready(gcd_ready), .gcd_valid(gcd_valid),
    .gcd_mod(gcd_mod), .gcd_fn(gcd_fn),
    .busy(busy), .done(done), .fail(fail),
    .key_mod(key_mod), .key_fn(key_fn), .attempts(attempts)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural GCD unit ----------------
  logic [EW-1:0]  e_val = 3'd7;
  int             lat = 6;
  bit             stall = 1'b0;
  logic           m_busy = 1'b0;
  int             m_cnt = 0;
  logic [H-1:0]   m_p1 = '0;
  logic [H-1:0]   m_p2 = '0;
  logic [2*H-1:0] m_mod;
  logic [2*H-1:0] m_fn;
  logic           m_ok;

  function automatic logic [63:0] gcd_f(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] t;
    x = a;
    y = b;
    while (y != 64'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign m_mod = {{H{1'b0}}, m_p1} * {{H{1'b0}}, m_p2};
  assign m_fn  = {{H{1'b0}}, m_p1 - 16'd1} * {{H{1'b0}}, m_p2 - 16'd1};
  assign m_ok  = (gcd_f(64'(m_fn), 64'(e_val)) == 64'd1);

  // GCD model: result appears lat cycles after the start pulse, cleared by gcd_rst.
  always @(posedge clk) begin
    if (!gcd_rst) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      gcd_ready <= 1'b0;
      gcd_valid <= 1'b0;
      gcd_mod   <= '0;
      gcd_fn    <= '0;
    end else if (gcd_start) begin
      m_busy    <= 1'b1;
      m_cnt     <= lat;
      m_p1      <= gcd_p1;
      m_p2      <= gcd_p2;
      gcd_ready <= 1'b0;
    end else if (m_busy && !stall) begin
      if (m_cnt <= 1) begin
        m_busy    <= 1'b0;
        gcd_ready <= 1'b1;
        gcd_valid <= m_ok;
        gcd_mod   <= m_mod;
        gcd_fn    <= m_fn;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Bounded wait at negedges until the selected output reaches lvl.
  task automatic wait_sig(input string name, input int sel, input logic lvl, input int budget, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (sel)
        0:       s = cand_ready;
        1:       s = gcd_start;
        2:       s = gcd_rst;
        default: s = busy;
      endcase
    end while (s !== lvl && n < budget);
    if (s !== lvl) chk({name, "_wait_expired"}, 64'(s), 64'(lvl));
  endtask

  // ---------------- table of whole searches ----------------
  typedef struct {
    logic [EW-1:0]  e;
    logic [H-1:0]   a1, a2, b1, b2;
    bit             go_noise;
    bit             exp_done;
    logic [2*H-1:0] exp_mod, exp_fn;
    int             exp_att, exp_starts, exp_flush;
  } vec_t;

  vec_t vecs[8];
  logic [2*H-1:0] exp_q[$];

  // Run one search: drive go, offer pairs when asked, monitor outputs every cycle.
  task automatic run_search(input vec_t v, output int n_start, output int n_flush, output int n_req,
                            output int max_run, output int first_start, output bit finished);
    logic [H-1:0] p1s[2];
    logic [H-1:0] p2s[2];
    logic [2*H-1:0] got;
    logic [2*H-1:0] want;
    int  ci;
    int  cyc;
    int  run;
    bit  prev_rdy;
    bit  seen_busy;
    p1s[0] = v.a1; p2s[0] = v.a2; p1s[1] = v.b1; p2s[1] = v.b2;
    ci = 0; cyc = 0; run = 0; prev_rdy = 1'b0; seen_busy = 1'b0;
    n_start = 0; n_flush = 0; n_req = 0; max_run = 0; first_start = -1; finished = 1'b0;
    e_val = v.e;
    exp_q.delete();
    @(negedge clk);
    go = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gcd_start === 1'b1) begin
        n_start++;
        if (first_start < 0) first_start = cyc;
        got = {gcd_p1, gcd_p2};
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_start", 64'(got), 64'd0);
        end else begin
          want = exp_q.pop_front();
          chk("sb_gcd_operands", 64'(got), 64'(want));
        end
      end
      if (gcd_rst === 1'b0) begin
        n_flush++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (cand_ready === 1'b1 && !prev_rdy) n_req++;
      prev_rdy = (cand_ready === 1'b1);
      if (cand_ready === 1'b1 && ci < 2) begin
        cand_valid = 1'b1;
        cand_p1 = p1s[ci];
        cand_p2 = p2s[ci];
        if (p1s[ci] != p2s[ci] && p1s[ci] != 16'd0 && p2s[ci] != 16'd0)
          exp_q.push_back({p1s[ci], p2s[ci]});
        ci++;
      end else begin
        cand_valid = 1'b0;
      end
      if (busy === 1'b1) seen_busy = 1'b1;
      go = v.go_noise && (busy === 1'b1);
      if (seen_busy && busy === 1'b0) finished = 1'b1;
    end
    go = 1'b0;
    cand_valid = 1'b0;
  endtask

  initial begin
    int n_start, n_flush, n_req, max_run, first_start, n;
    bit fin;
    rst = 1'b0; go = 1'b0; cand_valid = 1'b0; cand_p1 = '0; cand_p2 = '0;

    //          e     a1         a2         b1      b2     noise done mod              fn              att st fl
    vecs[0] = '{3'd7, 16'd11,    16'd13,    16'd0,  16'd0, 1'b0, 1'b1, 32'd143,        32'd120,        1, 1, 1};
    vecs[1] = '{3'd3, 16'd7,     16'd13,    16'd11, 16'd17, 1'b0, 1'b1, 32'd187,       32'd160,        2, 2, 2};
    vecs[2] = '{3'd3, 16'd7,     16'd13,    16'd7,  16'd19, 1'b0, 1'b0, 32'd187,       32'd160,        2, 2, 3};
    vecs[3] = '{3'd3, 16'd13,    16'd13,    16'd0,  16'd5, 1'b0, 1'b0, 32'd187,        32'd160,        2, 0, 3};
    vecs[4] = '{3'd5, 16'd3,     16'd7,     16'd0,  16'd0, 1'b0, 1'b1, 32'd21,         32'd12,         1, 1, 1};
    vecs[5] = '{3'd5, 16'd11,    16'd31,    16'd5,  16'd0, 1'b0, 1'b0, 32'd21,         32'd12,         2, 1, 3};
    vecs[6] = '{3'd3, 16'd65535, 16'd65534, 16'd0,  16'd0, 1'b0, 1'b1, 32'd4294770690, 32'd4294639622, 1, 1, 1};
    vecs[7] = '{3'd7, 16'd0,     16'd13,    16'd11, 16'd13, 1'b1, 1'b1, 32'd143,       32'd120,        2, 1, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_gcd_rst", 64'(gcd_rst), 64'd0);
    chk("rst_cand_ready", 64'(cand_ready), 64'd0);
    chk("rst_gcd_start", 64'(gcd_start), 64'd0);
    chk("rst_attempts", 64'(attempts), 64'd0);
    chk("rst_key_mod", 64'(key_mod), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_gcd_rst", 64'(gcd_rst), 64'd1);

    // Table-driven searches
    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i], n_start, n_flush, n_req, max_run, first_start, fin);
      chk($sformatf("v%0d_finished", i), 64'(fin), 64'd1);
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_fail", i), 64'(fail), 64'(!vecs[i].exp_done));
      chk($sformatf("v%0d_key_mod", i), 64'(key_mod), 64'(vecs[i].exp_mod));
      chk($sformatf("v%0d_key_fn", i), 64'(key_fn), 64'(vecs[i].exp_fn));
      chk($sformatf("v%0d_attempts", i), 64'(attempts), 64'(vecs[i].exp_att));
      chk($sformatf("v%0d_gcd_starts", i), 64'(n_start), 64'(vecs[i].exp_starts));
      chk($sformatf("v%0d_flush_cycles", i), 64'(n_flush), 64'(vecs[i].exp_flush));
      chk($sformatf("v%0d_flush_run", i), 64'(max_run), 64'd1);
      chk($sformatf("v%0d_req_count", i), 64'(n_req), 64'(vecs[i].exp_att));
      chk($sformatf("v%0d_sb_empty", i), 64'(exp_q.size()), 64'd0);
      chk($sformatf("v%0d_cand_ready_idle", i), 64'(cand_ready), 64'd0);
      if (vecs[i].a1 != vecs[i].a2 && vecs[i].a1 != 16'd0 && vecs[i].a2 != 16'd0)
        chk($sformatf("v%0d_go_to_start", i), 64'(first_start), 64'd3);
    end

    // Timeout: GCD never answers, so WAIT lasts exactly TO cycles, then a retry.
    e_val = 3'd7; stall = 1'b1;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_sig("to_req1", 0, 1'b1, 20, n);
    cand_valid = 1'b1; cand_p1 = 16'd11; cand_p2 = 16'd13;
    @(negedge clk); cand_valid = 1'b0;
    chk("to_kick", 64'(gcd_start), 64'd1);
    wait_sig("to_flush", 2, 1'b0, 300, n);
    chk("to_wait_len", 64'(n), 64'(TO + 1));
    chk("to_attempts", 64'(attempts), 64'd1);
    @(negedge clk);
    chk("to_req2", 64'(cand_ready), 64'd1);
    stall = 1'b0;
    cand_valid = 1'b1;
    @(negedge clk); cand_valid = 1'b0;
    wait_sig("to_end", 3, 1'b0, 200, n);
    chk("to_done", 64'(done), 64'd1);
    chk("to_attempts_final", 64'(attempts), 64'd2);
    chk("to_key_mod", 64'(key_mod), 64'd143);

    // Ready arrives on the very cycle the timer expires: the result wins.
    e_val = 3'd5; lat = TO - 1;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_sig("co_req", 0, 1'b1, 20, n);
    cand_valid = 1'b1; cand_p1 = 16'd3; cand_p2 = 16'd7;
    @(negedge clk); cand_valid = 1'b0;
    wait_sig("co_end", 3, 1'b0, 300, n);
    chk("co_done", 64'(done), 64'd1);
    chk("co_attempts", 64'(attempts), 64'd1);
    chk("co_key_mod", 64'(key_mod), 64'd21);
    chk("co_key_fn", 64'(key_fn), 64'd12);

    // Reset in the middle of WAIT aborts with everything cleared.
    e_val = 3'd7; lat = 50;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    wait_sig("mr_req", 0, 1'b1, 20, n);
    cand_valid = 1'b1; cand_p1 = 16'd11; cand_p2 = 16'd13;
    @(negedge clk); cand_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_gcd_rst", 64'(gcd_rst), 64'd0);
    chk("mr_attempts", 64'(attempts), 64'd0);
    chk("mr_key_mod", 64'(key_mod), 64'd0);
    chk("mr_gcd_p1", 64'(gcd_p1), 64'd0);
    chk("mr_done_fail", 64'({done, fail, cand_ready, gcd_start}), 64'd0);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("mr_idle_done", 64'(done), 64'd0);
    chk("mr_idle_busy", 64'(busy), 64'd0);
    chk("mr_idle_gcd_rst", 64'(gcd_rst), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
